// File: rtl/reg_cmd_serializer.sv
// reg_cmd_serializer: buffers register writes and emits each as an SI byte frame.
// Optional macro CMD_SERIALIZER_CHECKSUM_EN appends an XOR checksum byte.
module reg_cmd_serializer #(
   parameter int REG_ADDR_WIDTH = 8,
   parameter int REG_DATA_WIDTH = 16,
   parameter int TX_DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [REG_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [REG_DATA_WIDTH-1:0]   cmd_data,
   input  logic                        cmd_rdy,
   output logic                        cmd_ack,
   output logic [TX_DATA_WIDTH-1:0]    tx_data,
   output logic                        tx_rdy,
   input  logic                        tx_ack,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA_H,
      ST_DATA_L
`ifdef CMD_SERIALIZER_CHECKSUM_EN
      ,
      ST_CSUM
`endif
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [REG_ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
   logic [REG_DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
   logic [PW-1:0]             r_wr_ptr;
   logic [PW-1:0]             r_rd_ptr;
   logic [CW-1:0]             r_count;

   logic [REG_ADDR_WIDTH-1:0] r_frame_addr;
   logic [REG_DATA_WIDTH-1:0] r_frame_data;

   logic                      w_full;
   logic                      w_empty;
   logic                      w_push;
   logic                      w_pop;
   logic [TX_DATA_WIDTH-1:0]  w_addr_ext;
   logic [TX_DATA_WIDTH-1:0]  w_byte_h;
   logic [TX_DATA_WIDTH-1:0]  w_byte_l;
   logic [TX_DATA_WIDTH-1:0]  w_tx_data;
   logic                      w_tx_rdy;
   state_t                    w_after_last;
`ifdef CMD_SERIALIZER_CHECKSUM_EN
   logic [TX_DATA_WIDTH-1:0]  w_csum;
`endif

   // Full is taken from registered count only, so a same-cycle pop never frees a slot.
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = cmd_rdy && !w_full;

   assign cmd_ack    = !w_full;
   assign fifo_count = r_count;
   assign busy       = (r_state != ST_IDLE) || !w_empty;
   assign tx_data    = w_tx_data;
   assign tx_rdy     = w_tx_rdy;

   always_comb begin
      w_addr_ext = '0;
      w_addr_ext[REG_ADDR_WIDTH-1:0] = r_frame_addr;
   end

   assign w_byte_h = r_frame_data[2*TX_DATA_WIDTH-1:TX_DATA_WIDTH];
   assign w_byte_l = r_frame_data[TX_DATA_WIDTH-1:0];
`ifdef CMD_SERIALIZER_CHECKSUM_EN
   assign w_csum = w_addr_ext ^ w_byte_h ^ w_byte_l;
`endif

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wr_ptr] <= cmd_addr;
         r_mem_data[r_wr_ptr] <= cmd_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_frame_addr <= '0;
         r_frame_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) begin
            r_frame_addr <= r_mem_addr[r_rd_ptr];
            r_frame_data <= r_mem_data[r_rd_ptr];
         end
      end
   end

   // Back-to-back frames: the last byte's ack pops the next entry directly.
   assign w_after_last = w_empty ? ST_IDLE : ST_ADDR;

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_tx_rdy    = 1'b0;
      w_tx_data   = '0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            w_tx_rdy  = 1'b1;
            w_tx_data = w_addr_ext;
            if (tx_ack) w_state_nxt = ST_DATA_H;
         end
         ST_DATA_H: begin
            w_tx_rdy  = 1'b1;
            w_tx_data = w_byte_h;
            if (tx_ack) w_state_nxt = ST_DATA_L;
         end
         ST_DATA_L: begin
            w_tx_rdy  = 1'b1;
            w_tx_data = w_byte_l;
            if (tx_ack) begin
`ifdef CMD_SERIALIZER_CHECKSUM_EN
               w_state_nxt = ST_CSUM;
`else
               w_pop       = !w_empty;
               w_state_nxt = w_after_last;
`endif
            end
         end
`ifdef CMD_SERIALIZER_CHECKSUM_EN
         ST_CSUM: begin
            w_tx_rdy  = 1'b1;
            w_tx_data = w_csum;
            if (tx_ack) begin
               w_pop       = !w_empty;
               w_state_nxt = w_after_last;
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_cmd_serializer.sv
// tb_reg_cmd_serializer: scoreboard bench for the register command serializer.
// Expected frame bytes are queued at issue time and consumed by a negedge monitor.
module tb_reg_cmd_serializer;

`ifdef CMD_SERIALIZER_CHECKSUM_EN
   localparam int FRAME_LEN = 4;
`else
   localparam int FRAME_LEN = 3;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [15:0] cmd_data = '0;
   logic        cmd_rdy = 1'b0;
   logic        cmd_ack;
   logic [7:0]  tx_data;
   logic        tx_rdy;
   logic        tx_ack = 1'b0;
   logic [2:0]  fifo_count;
   logic        busy;

   int checks = 0;
   int failures = 0;
   logic [7:0] sb [$];
   logic pend = 1'b0;

   reg_cmd_serializer #(
      .REG_ADDR_WIDTH(8),
      .REG_DATA_WIDTH(16),
      .TX_DATA_WIDTH (8),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .cmd_rdy   (cmd_rdy),
      .cmd_ack   (cmd_ack),
      .tx_data   (tx_data),
      .tx_rdy    (tx_rdy),
      .tx_ack    (tx_ack),
      .fifo_count(fifo_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic exp_frame(input logic [7:0] a, input logic [15:0] d);
      sb.push_back(a);
      sb.push_back(d[15:8]);
      sb.push_back(d[7:0]);
`ifdef CMD_SERIALIZER_CHECKSUM_EN
      sb.push_back(a ^ d[15:8] ^ d[7:0]);
`endif
   endtask

   // Present a request for the next edge; cmd_ack must match the expectation.
   task automatic drive_cmd(input string name, input logic [7:0] a,
                            input logic [15:0] d, input logic acc);
      cmd_addr = a;
      cmd_data = d;
      cmd_rdy  = 1'b1;
      chk(name, 32'(cmd_ack), 32'(acc));
      if (acc) exp_frame(a, d);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         tick();
         n++;
      end
      chk(name, 32'(sb.size()), 0);
      chk({name, "_idle"}, 32'(busy), 0);
   endtask

   // Monitor: every presented byte must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            checks++;
            if (!tx_rdy) begin
               failures++;
               $display("FAIL tx_rdy_hold act=0 exp=1");
            end
         end
         if (tx_rdy) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_byte act=%0h exp=none", tx_data);
            end else begin
               if (tx_data !== sb[0]) begin
                  failures++;
                  $display("FAIL tx_byte act=%0h exp=%0h", tx_data, sb[0]);
               end
               if (tx_ack) void'(sb.pop_front());
            end
         end
         pend = tx_rdy && !tx_ack;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("rst_tx_rdy", 32'(tx_rdy), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_cmd_ack", 32'(cmd_ack), 1);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b1;
      tick();

      // Single command, ack held high
      tx_ack = 1'b1;
      drive_cmd("single_ack", 8'h05, 16'hA1B2, 1'b1);
      tick();
      cmd_rdy = 1'b0;
      chk("lat_count", 32'(fifo_count), 1);
      chk("lat_rdy_lo", 32'(tx_rdy), 0);
      tick();
      chk("lat_rdy_hi", 32'(tx_rdy), 1);
      chk("lat_byte0", 32'(tx_data), 32'h05);
      repeat (FRAME_LEN) tick();
      chk("single_done", 32'(sb.size()), 0);
      chk("single_busy", 32'(busy), 0);

      // Backpressure: ack toggles every cycle
      tx_ack = 1'b0;
      drive_cmd("bp_ack", 8'h05, 16'hA1B2, 1'b1);
      tick();
      cmd_rdy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0 && !busy) break;
         tx_ack = !tx_ack;
         tick();
      end
      chk("bp_done", 32'(sb.size()), 0);
      tx_ack = 1'b0;
      tick();

      // FIFO full: five accepted, sixth dropped
      for (int i = 1; i <= 6; i++) begin
         drive_cmd($sformatf("full_ack%0d", i), 8'(i), 16'(i), i <= 5);
         tick();
      end
      cmd_rdy = 1'b0;
      chk("full_count", 32'(fifo_count), 4);
      chk("full_cmd_ack", 32'(cmd_ack), 0);
      chk("full_head", 32'(tx_data), 32'h01);
      tx_ack = 1'b1;
      repeat (5 * FRAME_LEN) tick();
      chk("full_gapless", 32'(sb.size()), 0);
      chk("full_busy", 32'(busy), 0);

      // Push on the same edge as the last-byte ack
      tx_ack = 1'b0;
      drive_cmd("pp_a", 8'h21, 16'hC0DE, 1'b1);
      tick();
      drive_cmd("pp_b", 8'h32, 16'hBEEF, 1'b1);
      tick();
      drive_cmd("pp_c", 8'h43, 16'h1234, 1'b1);
      tick();
      cmd_rdy = 1'b0;
      chk("pp_count_pre", 32'(fifo_count), 2);
      tx_ack = 1'b1;
      repeat (FRAME_LEN - 1) tick();
      drive_cmd("pp_d", 8'h54, 16'h5A5A, 1'b1);
      tick();
      cmd_rdy = 1'b0;
      chk("pp_count", 32'(fifo_count), 2);
      chk("pp_next_addr", 32'(tx_data), 32'h32);
      drain("pp_drain");

      // Reset while in DATA_H with two queued
      tx_ack = 1'b0;
      drive_cmd("mr_e", 8'h65, 16'h0F0F, 1'b1);
      tick();
      drive_cmd("mr_f", 8'h76, 16'hF0F0, 1'b1);
      tick();
      drive_cmd("mr_g", 8'h87, 16'h3C3C, 1'b1);
      tick();
      cmd_rdy = 1'b0;
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      chk("mr_count_pre", 32'(fifo_count), 2);
      chk("mr_in_data_h", 32'(tx_data), 32'h0F);
      #2;
      rst = 1'b0;
      #1;
      chk("mr_tx_rdy", 32'(tx_rdy), 0);
      chk("mr_tx_data", 32'(tx_data), 0);
      chk("mr_count", 32'(fifo_count), 0);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_cmd_ack", 32'(cmd_ack), 1);
      sb.delete();
      tick();
      rst = 1'b1;
      tx_ack = 1'b1;
      repeat (10) tick();
      chk("mr_quiet_rdy", 32'(tx_rdy), 0);
      chk("mr_quiet_busy", 32'(busy), 0);
      drive_cmd("mr_new", 8'h98, 16'h6789, 1'b1);
      tick();
      cmd_rdy = 1'b0;
      drain("mr_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_cmd_serializer.md
# reg_cmd_serializer

Command-frame transmitter for the register write path. It accepts register write requests (address plus data), buffers them in a small FIFO, and serializes each one into a byte frame on a simple-interface (SI) output. The frame format matches what the register receive block decodes. The block is used for FT245 loopback self-test and for controller-side builds that drive the scope over the SI byte stream.

## Interface
Parameters:
- REG_ADDR_WIDTH, 8: register address width; must be ≤ TX_DATA_WIDTH.
- REG_DATA_WIDTH, 16: register data width; must equal 2·TX_DATA_WIDTH.
- TX_DATA_WIDTH, 8: SI byte width.
- FIFO_DEPTH, 4: command FIFO entries; must be a power of two and ≥ 2.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  asynchronous, active-low reset.
- cmd_addr  in  REG_ADDR_WIDTH  register address of the request.
- cmd_data  in  REG_DATA_WIDTH  register value of the request.
- cmd_rdy  in  1  request valid.
- cmd_ack  out  1  FIFO can accept a request.
- tx_data  out  TX_DATA_WIDTH  frame byte.
- tx_rdy  out  1  tx_data valid.
- tx_ack  in  1  downstream accepts the byte.
- fifo_count  out  log2(FIFO_DEPTH)+1  occupied entries.
- busy  out  1  a frame is in flight or the FIFO is non-empty.

## Operation
- **Frame format:** byte0 = address, zero-extended to TX_DATA_WIDTH; byte1 = data[15:8]; byte2 = data[7:0]. The checksum byte is optional; see Configuration.
- **Push:**
  - cmd_ack = !full, computed from registered state.
  - A push occurs when cmd_rdy && cmd_ack.
  - While full, pushes are refused even if a pop happens in the same cycle.
- **Pop:** a pop occurs only on a state transition into ADDR.
- **Simultaneous push and pop** when not full: fifo_count is unchanged.
- **Pointers:** wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, ADDR, DATA_H, DATA_L, CSUM (CSUM exists only with the macro).
  - IDLE: if fifo_count ≠ 0, pop, load the frame register, go to ADDR.
  - ADDR / DATA_H / DATA_L: tx_rdy=1 with the corresponding byte. On tx_ack, advance to the next state.
  - Last byte acked: go to ADDR with a new pop if the FIFO is non-empty (no bubble); otherwise go to IDLE.
- **Output stability:** tx_data is stable while tx_rdy=1 and tx_ack=0. tx_rdy never drops before its ack.
- **busy** = (state ≠ IDLE) || (fifo_count ≠ 0).

## Timing
- **Reset values:** state IDLE, tx_rdy=0, tx_data=0, cmd_ack=1, fifo_count=0, busy=0, FIFO pointers 0.
- **Reset mid-frame:** the frame is abandoned, the FIFO is flushed, and all outputs return to reset values asynchronously.
- **Latency:** a push into an empty FIFO at edge N gives fifo_count=1 after N. The pop/ADDR transition occurs at N+1, so tx_rdy=1 after edge N+1.
- **Throughput:** with tx_ack held high, one byte per cycle, including across frame boundaries.
- **tx_ack while tx_rdy=0:** ignored.
- **cmd_rdy while cmd_ack=0:** ignored; the request is not stored and no error is flagged.

## Configuration
- **CMD_SERIALIZER_CHECKSUM_EN defined:** a fourth byte is sent after DATA_L, in state CSUM. Its value is the XOR of byte0, byte1 and byte2. The frame is 4 bytes.
- **Macro undefined:** the CSUM state and logic are absent. DATA_L goes directly to ADDR or IDLE. The frame is 3 bytes.

## Test plan
- **Single command:** after reset, push addr 0x05, data 0xA1B2, with tx_ack held 1.
  - Macro undefined: bytes 0x05, 0xA1, 0xB2 on consecutive cycles; tx_rdy first high one cycle after the push edge.
  - Macro defined: 0x16 follows as the fourth byte.
- **Backpressure:** same command with tx_ack toggling 0/1 every cycle → each byte is held stable until acked; the byte sequence is unchanged.
- **FIFO full:** with tx_ack=0, push 5 commands (0x01/0x0001 … 0x05/0x0005).
  - The first is popped into ADDR. The FIFO then fills with 4 entries, cmd_ack=0 and the 6th request is dropped.
  - With tx_ack=1, 5 frames are sent in order with no idle cycles between them.
- **Push and pop in the same cycle:** at fifo_count=2, push on the same cycle as the last-byte ack → fifo_count stays 2.
- **Reset mid-frame:** assert rst during DATA_H with 2 queued commands.
  - tx_rdy=0, fifo_count=0 and busy=0 immediately.
  - After release, no bytes are emitted until a new push.
